// File: rtl/rx.sv
// UART receiver: start bit, 8 data bits LSB first, even parity, stop bit; one-cycle Rx_Done.
// Optional stop-bit check enabled by defining RX_STOP_CHECK_EN (adds STOP state and Framing_Error).
module rx #(
    parameter int unsigned CLKS_PER_BIT = 434,
    parameter int unsigned HALF_BIT     = CLKS_PER_BIT / 2
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       Rx,
    output logic [7:0] Data_received,
    output logic       Rx_Done,
    output logic       Parity_Error,
    output logic       Rx_Busy,
    output logic       Framing_Error
);

    localparam int unsigned CNT_W = 9;
    localparam logic [CNT_W-1:0] HALF_M1 = CNT_W'(HALF_BIT - 1);
    localparam logic [CNT_W-1:0] BIT_M1  = CNT_W'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } state_t;

    state_t           state, state_n;
    logic [CNT_W-1:0] cnt, cnt_n;
    logic [2:0]       bit_idx, bit_idx_n;
    logic [7:0]       shift, shift_n;
    logic [7:0]       data_n;
    logic             done_n, perr_n, busy_n;
    logic             rx_m, rx_s, rx_prev;
    logic             start_edge;

`ifdef RX_STOP_CHECK_EN
    logic ferr_n, perr_pend, perr_pend_n;
`endif

    assign start_edge = !rx_s && rx_prev;

    // Two-flop synchroniser plus previous-sample register; all idle high
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rx_m    <= 1'b1;
            rx_s    <= 1'b1;
            rx_prev <= 1'b1;
        end else begin
            rx_m    <= Rx;
            rx_s    <= rx_m;
            rx_prev <= rx_s;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state         <= IDLE;
            cnt           <= '0;
            bit_idx       <= '0;
            shift         <= '0;
            Data_received <= '0;
            Rx_Done       <= 1'b0;
            Parity_Error  <= 1'b0;
            Rx_Busy       <= 1'b0;
        end else begin
            state         <= state_n;
            cnt           <= cnt_n;
            bit_idx       <= bit_idx_n;
            shift         <= shift_n;
            Data_received <= data_n;
            Rx_Done       <= done_n;
            Parity_Error  <= perr_n;
            Rx_Busy       <= busy_n;
        end
    end

`ifdef RX_STOP_CHECK_EN
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            Framing_Error <= 1'b0;
            perr_pend     <= 1'b0;
        end else begin
            Framing_Error <= ferr_n;
            perr_pend     <= perr_pend_n;
        end
    end
`else
    assign Framing_Error = 1'b0;
`endif

    always_comb begin
        state_n   = state;
        cnt_n     = cnt;
        bit_idx_n = bit_idx;
        shift_n   = shift;
        data_n    = Data_received;
        done_n    = 1'b0;
        perr_n    = Parity_Error;
        busy_n    = Rx_Busy;
`ifdef RX_STOP_CHECK_EN
        ferr_n      = Framing_Error;
        perr_pend_n = perr_pend;
`endif
        case (state)
            IDLE: begin
                cnt_n     = '0;
                bit_idx_n = '0;
                // Edge, not level, so a low line left over from a frame cannot re-trigger
                if (start_edge) begin
                    state_n = START;
                    busy_n  = 1'b1;
                end
            end
            START: begin
                if (cnt == HALF_M1) begin
                    cnt_n = '0;
                    if (rx_s) begin
                        state_n = IDLE;
                        busy_n  = 1'b0;
                    end else begin
                        state_n = DATA;
                    end
                end else begin
                    cnt_n = CNT_W'(cnt + 1'b1);
                end
            end
            DATA: begin
                if (cnt == BIT_M1) begin
                    cnt_n     = '0;
                    shift_n   = {rx_s, shift[7:1]};
                    bit_idx_n = 3'(bit_idx + 3'd1);
                    if (bit_idx == 3'd7) state_n = PARITY;
                end else begin
                    cnt_n = CNT_W'(cnt + 1'b1);
                end
            end
            PARITY: begin
                if (cnt == BIT_M1) begin
                    cnt_n = '0;
`ifdef RX_STOP_CHECK_EN
                    perr_pend_n = rx_s ^ (^shift);
                    state_n     = STOP;
`else
                    data_n  = shift;
                    perr_n  = rx_s ^ (^shift);
                    done_n  = 1'b1;
                    busy_n  = 1'b0;
                    state_n = IDLE;
`endif
                end else begin
                    cnt_n = CNT_W'(cnt + 1'b1);
                end
            end
`ifdef RX_STOP_CHECK_EN
            STOP: begin
                if (cnt == BIT_M1) begin
                    cnt_n   = '0;
                    data_n  = shift;
                    perr_n  = perr_pend;
                    ferr_n  = !rx_s;
                    done_n  = 1'b1;
                    busy_n  = 1'b0;
                    state_n = IDLE;
                end else begin
                    cnt_n = CNT_W'(cnt + 1'b1);
                end
            end
`endif
            default: begin
                state_n = IDLE;
                busy_n  = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_rx.sv
// Directed bench for the UART receiver: reset, frames, parity, glitch, mid-frame reset, back-to-back.
`timescale 1ns/1ps
module tb_rx;

    localparam int CPB = 434;
`ifdef RX_STOP_CHECK_EN
    localparam int BUSY_FRAME = 4123 + CPB;
`else
    localparam int BUSY_FRAME = 4123;
`endif

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       Rx    = 1'b1;
    logic [7:0] Data_received;
    logic       Rx_Done;
    logic       Parity_Error;
    logic       Rx_Busy;
    logic       Framing_Error;

    int checks   = 0;
    int failures = 0;

    // Observation counters written only by the monitor
    int         done_cnt  = 0;
    int         busy_cyc  = 0;
    logic [7:0] cap_data [0:15];
    logic       cap_perr [0:15];
    logic       cap_ferr [0:15];

    rx #(.CLKS_PER_BIT(CPB)) dut (
        .clock         (clock),
        .reset         (reset),
        .Rx            (Rx),
        .Data_received (Data_received),
        .Rx_Done       (Rx_Done),
        .Parity_Error  (Parity_Error),
        .Rx_Busy       (Rx_Busy),
        .Framing_Error (Framing_Error)
    );

    always #10 clock = ~clock;

    always @(negedge clock) begin
        if (Rx_Done) begin
            cap_data[done_cnt[3:0]] = Data_received;
            cap_perr[done_cnt[3:0]] = Parity_Error;
            cap_ferr[done_cnt[3:0]] = Framing_Error;
            done_cnt = done_cnt + 1;
        end
        if (Rx_Busy) busy_cyc = busy_cyc + 1;
    end

    task automatic drive_bit(input logic b);
        Rx = b;
        repeat (CPB) @(posedge clock);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic par, input logic stop);
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) drive_bit(d[i]);
        drive_bit(par);
        drive_bit(stop);
        Rx = 1'b1;
    endtask

    task automatic test_reset;
        int d0, b0;
        reset = 1'b1;
        repeat (5) @(posedge clock);
        @(negedge clock);
        checks++; if (Data_received !== 8'h00) begin failures++; $display("FAIL reset_data got=%h exp=00", Data_received); end
        checks++; if (Rx_Done !== 1'b0) begin failures++; $display("FAIL reset_done got=%b exp=0", Rx_Done); end
        checks++; if (Parity_Error !== 1'b0) begin failures++; $display("FAIL reset_perr got=%b exp=0", Parity_Error); end
        checks++; if (Rx_Busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", Rx_Busy); end
        checks++; if (Framing_Error !== 1'b0) begin failures++; $display("FAIL reset_ferr got=%b exp=0", Framing_Error); end
        reset = 1'b0;
        d0 = done_cnt; b0 = busy_cyc;
        repeat (1000) @(posedge clock);
        @(negedge clock);
        checks++; if (done_cnt - d0 !== 0) begin failures++; $display("FAIL idle_done got=%0d exp=0", done_cnt - d0); end
        checks++; if (busy_cyc - b0 !== 0) begin failures++; $display("FAIL idle_busy got=%0d exp=0", busy_cyc - b0); end
        checks++; if (Data_received !== 8'h00) begin failures++; $display("FAIL idle_data got=%h exp=00", Data_received); end
    endtask

    task automatic test_basic;
        int d0, b0;
        d0 = done_cnt; b0 = busy_cyc;
        send_frame(8'hA5, 1'b0, 1'b1);
        repeat (20) @(posedge clock);
        @(negedge clock);
        checks++; if (done_cnt - d0 !== 1) begin failures++; $display("FAIL a5_pulses got=%0d exp=1", done_cnt - d0); end
        checks++; if (cap_data[d0[3:0]] !== 8'hA5) begin failures++; $display("FAIL a5_data got=%h exp=a5", cap_data[d0[3:0]]); end
        checks++; if (cap_perr[d0[3:0]] !== 1'b0) begin failures++; $display("FAIL a5_perr got=%b exp=0", cap_perr[d0[3:0]]); end
        checks++; if (cap_ferr[d0[3:0]] !== 1'b0) begin failures++; $display("FAIL a5_ferr got=%b exp=0", cap_ferr[d0[3:0]]); end
        checks++;
        if ((busy_cyc - b0) < BUSY_FRAME - 1 || (busy_cyc - b0) > BUSY_FRAME + 1) begin
            failures++; $display("FAIL a5_busy_len got=%0d exp=%0d", busy_cyc - b0, BUSY_FRAME);
        end
        checks++; if (Data_received !== 8'hA5) begin failures++; $display("FAIL a5_hold got=%h exp=a5", Data_received); end
    endtask

    task automatic test_parity;
        int d0;
        d0 = done_cnt;
        send_frame(8'h01, 1'b0, 1'b1);
        repeat (20) @(posedge clock);
        @(negedge clock);
        checks++; if (done_cnt - d0 !== 1) begin failures++; $display("FAIL p01_pulses got=%0d exp=1", done_cnt - d0); end
        checks++; if (cap_data[d0[3:0]] !== 8'h01) begin failures++; $display("FAIL p01_data got=%h exp=01", cap_data[d0[3:0]]); end
        checks++; if (cap_perr[d0[3:0]] !== 1'b1) begin failures++; $display("FAIL p01_perr got=%b exp=1", cap_perr[d0[3:0]]); end
        checks++; if (Parity_Error !== 1'b1) begin failures++; $display("FAIL p01_perr_hold got=%b exp=1", Parity_Error); end
        d0 = done_cnt;
        send_frame(8'h03, 1'b0, 1'b1);
        repeat (20) @(posedge clock);
        @(negedge clock);
        checks++; if (done_cnt - d0 !== 1) begin failures++; $display("FAIL p03_pulses got=%0d exp=1", done_cnt - d0); end
        checks++; if (cap_data[d0[3:0]] !== 8'h03) begin failures++; $display("FAIL p03_data got=%h exp=03", cap_data[d0[3:0]]); end
        checks++; if (Parity_Error !== 1'b0) begin failures++; $display("FAIL p03_perr got=%b exp=0", Parity_Error); end
    endtask

    task automatic test_glitch;
        int d0, b0;
        d0 = done_cnt; b0 = busy_cyc;
        Rx = 1'b0;
        repeat (100) @(posedge clock);
        Rx = 1'b1;
        repeat (400) @(posedge clock);
        @(negedge clock);
        checks++; if (done_cnt - d0 !== 0) begin failures++; $display("FAIL glitch_done got=%0d exp=0", done_cnt - d0); end
        checks++;
        if ((busy_cyc - b0) < 216 || (busy_cyc - b0) > 218) begin
            failures++; $display("FAIL glitch_busy_len got=%0d exp=217", busy_cyc - b0);
        end
        checks++; if (Rx_Busy !== 1'b0) begin failures++; $display("FAIL glitch_busy_end got=%b exp=0", Rx_Busy); end
        checks++; if (Data_received !== 8'h03) begin failures++; $display("FAIL glitch_data got=%h exp=03", Data_received); end
    endtask

    task automatic test_reset_mid;
        int d0;
        logic [7:0] d;
        d  = 8'h5A;
        d0 = done_cnt;
        drive_bit(1'b0);
        for (int i = 0; i < 3; i++) drive_bit(d[i]);
        Rx = d[3];
        repeat (CPB / 2) @(posedge clock);
        checks++; if (Rx_Busy !== 1'b1) begin failures++; $display("FAIL mid_busy_pre got=%b exp=1", Rx_Busy); end
        reset = 1'b1;
        repeat (5) @(posedge clock);
        @(negedge clock);
        checks++; if (Rx_Busy !== 1'b0) begin failures++; $display("FAIL mid_busy_rst got=%b exp=0", Rx_Busy); end
        checks++; if (Data_received !== 8'h00) begin failures++; $display("FAIL mid_data_rst got=%h exp=00", Data_received); end
        reset = 1'b0;
        Rx = 1'b1;
        repeat (2 * CPB) @(posedge clock);
        @(negedge clock);
        checks++; if (done_cnt - d0 !== 0) begin failures++; $display("FAIL mid_no_done got=%0d exp=0", done_cnt - d0); end
        send_frame(8'h3C, 1'b0, 1'b1);
        repeat (20) @(posedge clock);
        @(negedge clock);
        checks++; if (done_cnt - d0 !== 1) begin failures++; $display("FAIL mid_3c_pulses got=%0d exp=1", done_cnt - d0); end
        checks++; if (Data_received !== 8'h3C) begin failures++; $display("FAIL mid_3c_data got=%h exp=3c", Data_received); end
        checks++; if (Parity_Error !== 1'b0) begin failures++; $display("FAIL mid_3c_perr got=%b exp=0", Parity_Error); end
    endtask

    task automatic test_back_to_back;
        int d0;
        d0 = done_cnt;
        send_frame(8'h00, 1'b0, 1'b1);
        send_frame(8'hFF, 1'b0, 1'b1);
        repeat (20) @(posedge clock);
        @(negedge clock);
        checks++; if (done_cnt - d0 !== 2) begin failures++; $display("FAIL b2b_pulses got=%0d exp=2", done_cnt - d0); end
        checks++; if (cap_data[d0[3:0]] !== 8'h00) begin failures++; $display("FAIL b2b_first got=%h exp=00", cap_data[d0[3:0]]); end
        checks++; if (cap_data[4'(d0 + 1)] !== 8'hFF) begin failures++; $display("FAIL b2b_second got=%h exp=ff", cap_data[4'(d0 + 1)]); end
        checks++;
        if (cap_perr[d0[3:0]] !== 1'b0 || cap_perr[4'(d0 + 1)] !== 1'b0) begin
            failures++; $display("FAIL b2b_perr got=%b%b exp=00", cap_perr[d0[3:0]], cap_perr[4'(d0 + 1)]);
        end
        checks++; if (Framing_Error !== 1'b0) begin failures++; $display("FAIL b2b_ferr got=%b exp=0", Framing_Error); end
    endtask

`ifdef RX_STOP_CHECK_EN
    task automatic test_stop_error;
        int d0;
        d0 = done_cnt;
        send_frame(8'h96, 1'b0, 1'b0);
        repeat (CPB) @(posedge clock);
        @(negedge clock);
        checks++; if (done_cnt - d0 !== 1) begin failures++; $display("FAIL stop_pulses got=%0d exp=1", done_cnt - d0); end
        checks++; if (Framing_Error !== 1'b1) begin failures++; $display("FAIL stop_ferr got=%b exp=1", Framing_Error); end
        checks++; if (Data_received !== 8'h96) begin failures++; $display("FAIL stop_data got=%h exp=96", Data_received); end
        checks++; if (Parity_Error !== 1'b0) begin failures++; $display("FAIL stop_perr got=%b exp=0", Parity_Error); end
    endtask
`endif

    initial begin
        test_reset;
        test_basic;
        test_parity;
        test_glitch;
        test_reset_mid;
        test_back_to_back;
`ifdef RX_STOP_CHECK_EN
        test_stop_error;
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
